// File: rtl/mem_responder_ram_pkg.sv
// Shared types, constants and address-range helper for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  MEM_WSTRB_READ = 4'b0000;
    localparam logic [31:0] ERR_DATA_DEF   = 32'hDEAD_BEEF;

    // Range test on the unwrapped difference, so addresses below base never alias high.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [33:0] diff;
        logic [33:0] span;
        diff = {2'b00, addr} - {2'b00, base};
        span = 34'(depth) << 2;
        return (addr >= base) && (diff < span);
    endfunction

endpackage

// File: rtl/sram_bytewise.sv
// Single-port synchronous RAM, registered read, read-before-write, per-byte write enables.
module sram_bytewise #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_o <= mem[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder_ram.sv
// Memory-side responder: word RAM with byte strobes, fixed wait states and
// alignment/range rejection reported through err_o.
module mem_responder_ram
    import mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          access;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   addr_a, wdata_a, off_a;
    logic [3:0]    wstrb_a;
    logic          ok_a;
    logic [AW-1:0] idx_a;
    logic          err_q, rd_q;
    logic [31:0]   hold_q, resp_data, ram_rdata;

    // With no wait states the access happens on the accept edge, before the latch holds anything.
    assign addr_a  = (state == IDLE) ? mem_addr_i  : addr_q;
    assign wdata_a = (state == IDLE) ? mem_wdata_i : wdata_q;
    assign wstrb_a = (state == IDLE) ? mem_wstrb_i : wstrb_q;

    assign ok_a  = (addr_a[1:0] == 2'b00) && addr_in_range(addr_a, BASE_ADDR, DEPTH_WORDS);
    assign off_a = addr_a - BASE_ADDR;
    assign idx_a = AW'(off_a >> 2);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid_i) begin
                    if (NO_WAIT) begin
                        access    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = WAIT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            err_q  <= 1'b0;
            rd_q   <= 1'b0;
            hold_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (access) begin
                err_q <= !ok_a;
                rd_q  <= (wstrb_a == MEM_WSTRB_READ);
            end
            if (state == RESP) hold_q <= resp_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == IDLE && mem_valid_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
        end
    end

    // Gating with reset drops a write still pending in WAIT.
    sram_bytewise #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk_i   (clk_i),
        .en_i    (access && rst_ni),
        .we_i    (ok_a ? wstrb_a : 4'b0000),
        .addr_i  (idx_a),
        .wdata_i (wdata_a),
        .rdata_o (ram_rdata)
    );

    assign resp_data   = rd_q ? (err_q ? ERR_DATA : ram_rdata) : 32'd0;
    assign mem_rdata_o = (state == RESP) ? resp_data : hold_q;
    assign mem_ready_o = (state == RESP);
    assign err_o       = (state == RESP) && err_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mem_responder_ram.sv
// Scoreboard bench: a driver pushes expected responses, a monitor pops and checks them.
module tb_mem_responder_ram;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WC    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid, ready, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;

    logic        v0, ready0, err0, busy0;
    logic [31:0] rdata0;

    mem_responder_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC),
                        .ERR_DATA(32'hDEAD_BEEF)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid), .mem_addr_i(addr),
        .mem_wdata_i(wdata), .mem_wstrb_i(wstrb), .mem_ready_o(ready),
        .mem_rdata_o(rdata), .err_o(err), .busy_o(busy));

    mem_responder_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0),
                        .ERR_DATA(32'hDEAD_BEEF)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(v0), .mem_addr_i(32'h0000_1002),
        .mem_wdata_i(32'h0), .mem_wstrb_i(4'h0), .mem_ready_o(ready0),
        .mem_rdata_o(rdata0), .err_o(err0), .busy_o(busy0));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return (a % 4 == 0) && (la >= BASE) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_rdata"}, rdata, e.rdata);
                chk({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
                chk({e.tag, "_cycle"}, cyc, e.cyc);
                chk({e.tag, "_busy"}, {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        exp_t e;
        int   w;
        bit   got;
        @(negedge clk);
        e.tag = tag;
        e.cyc = cyc + WC + 1;
        e.err = !addr_ok(a);
        w     = int'((a - BASE) >> 2);
        if (e.err)          e.rdata = (s == 4'h0) ? 32'hDEAD_BEEF : 32'h0;
        else if (s == 4'h0) e.rdata = model[w];
        else begin
            logic [31:0] old;
            old = model.exists(w) ? model[w] : 32'h0;
            for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
            model[w] = old;
            e.rdata  = 32'h0;
        end
        sb.push_back(e);
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = ready;
        end
        valid = 1'b0;
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] addr_pool [10] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1FF8,
                                     32'h1FFC, 32'h1002, 32'h2000, 32'h0FFC, 32'hFFFF_FFFC};

    initial begin
        int n;
        rst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; v0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        access("wr_full",   32'h1000, 32'h1234_5678, 4'hF);
        access("rd_full",   32'h1000, 32'h0,         4'h0);
        access("wr_part",   32'h1000, 32'hAABB_CCDD, 4'b0010);
        access("rd_part",   32'h1000, 32'h0,         4'h0);
        chk("model_part", model[0], 32'h1234_CC78);
        access("rd_misal",  32'h1002, 32'h0,         4'h0);
        access("wr_oor",    32'h2000, 32'h5555_5555, 4'hF);
        access("rd_after",  32'h1000, 32'h0,         4'h0);
        access("wr_last",   32'h1FFC, 32'hCAFE_0001, 4'hF);
        access("rd_last",   32'h1FFC, 32'h0,         4'h0);
        access("wr_1004",   32'h1004, 32'h0BAD_F00D, 4'hF);
        access("wr_1008",   32'h1008, 32'h0000_0008, 4'hF);
        access("wr_100c",   32'h100C, 32'h0000_000C, 4'hF);
        access("wr_1ff8",   32'h1FF8, 32'h0000_1FF8, 4'hF);

        // Reset during WAIT: the write to 0x1004 must vanish with no ready pulse.
        @(negedge clk);
        valid = 1'b1; addr = 32'h1004; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        @(negedge clk);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("rstw_busy",  {31'd0, busy},  32'd0);
        chk("rstw_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        access("rd_1004", 32'h1004, 32'h0, 4'h0);

        // Zero-wait instance, valid held: ready every second cycle, busy only in RESP.
        @(negedge clk);
        v0 = 1'b1;
        n = cyc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("w0_ready", {31'd0, ready0}, {31'd0, 1'((cyc - n) % 2)});
            chk("w0_busy",  {31'd0, busy0},  {31'd0, 1'((cyc - n) % 2)});
            if (ready0) begin
                chk("w0_err",   {31'd0, err0}, 32'd1);
                chk("w0_rdata", rdata0, 32'hDEAD_BEEF);
            end
        end
        v0 = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = addr_pool[$urandom_range(0, 9)];
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            access("rand", a, $urandom, s);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) chk("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
